// File: rtl/hazard_pkg.sv
// Shared FSM state type and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LU_WAIT = 2'd1,
    ST_MD_WAIT = 2'd2
  } hz_state_e;

  localparam int REG_AW_DEF = 5;
  localparam int ZERO_REG   = 0;
  localparam int LU_CNT_W   = 3;
  localparam int MD_CNT_W   = 5;

endpackage

// File: rtl/hazard_stall_cnt.sv
// Loadable down-counter that stops at zero and flags it; used for both the
// load-use and mul/div countdowns.
module hazard_stall_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-operand / mul-div hazard controller with stall and flush.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | no multi-cycle stall pending; hazards detected here
//   ST_LU_WAIT | remaining load-use bubbles after the detection cycle
//   ST_MD_WAIT | ID waits on HI/LO while the mul/div unit is busy
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LU_STALL = 1,
  parameter int MD_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_read,
  input  logic              ex_mem_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] ex_mem_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              br,
  input  logic              cmp_in,
  input  logic              jump,
  input  logic              md_start,
  input  logic              if_id_reads_hilo,
  output logic              if_id_wr_en,
  output logic              pc_wr_en,
  output logic              nop_flag,
  output logic              flush_flag,
  output logic              md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [REG_AW-1:0]   ZERO_R  = REG_AW'(ZERO_REG);
  localparam logic [LU_CNT_W-1:0] LU_LOAD = LU_CNT_W'(LU_STALL - 1);
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  hz_state_e             state_q, state_d;
  logic                  armed_q;
  logic                  br_hold_q;
  logic [LU_CNT_W-1:0]   lu_cnt;
  logic                  lu_zero;
  logic [MD_CNT_W-1:0]   md_cnt;
  logic                  md_zero;
  logic                  lu_hz, br_hz, md_hz, stall;
  logic                  md_load;

  // armed_q keeps hazard detection off until the first edge after reset
  assign lu_hz = armed_q && (state_q != ST_LU_WAIT) && id_ex_mem_read &&
                 (id_ex_rt != ZERO_R) &&
                 ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  // br_hold_q limits a branch-operand stall to one cycle even if inputs linger
  assign br_hz = armed_q && !br_hold_q && br && ex_mem_mem_read &&
                 (ex_mem_rt != ZERO_R) &&
                 ((ex_mem_rt == if_id_rs) || (ex_mem_rt == if_id_rt));

  assign md_busy = !md_zero;
  assign md_hz   = armed_q && md_busy && if_id_reads_hilo;
  assign md_load = armed_q && md_start && md_zero;

  assign stall = lu_hz || (state_q == ST_LU_WAIT) || br_hz || md_hz;

  assign if_id_wr_en = !stall;
  assign pc_wr_en    = !stall;
  assign nop_flag    = stall;
  assign flush_flag  = armed_q && !stall && ((br && cmp_in) || jump);

  hazard_stall_cnt #(.W(LU_CNT_W)) u_lu_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lu_hz),
    .load_val (LU_LOAD),
    .cnt      (lu_cnt),
    .zero     (lu_zero)
  );

  hazard_stall_cnt #(.W(MD_CNT_W)) u_md_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (md_load),
    .load_val (MD_LOAD),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );

  // Load-use outranks mul/div; a state is kept only while its stall continues next cycle
  always_comb begin
    state_d = ST_IDLE;
    if ((lu_hz && (LU_STALL > 1)) ||
        ((state_q == ST_LU_WAIT) && !lu_zero && (lu_cnt != LU_CNT_W'(1)))) begin
      state_d = ST_LU_WAIT;
    end else if (md_hz && (md_cnt > MD_CNT_W'(1))) begin
      state_d = ST_MD_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      br_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      br_hold_q <= br_hz;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_flag && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
